frame_pingpong_buf: RTL and testbench
=====================================

# frame_pingpong_buf

Sample-capture buffer downstream of the 1024-sample frame address generator. Writes AD9283 8-bit samples into a two-page ping-pong RAM at the generator's address and page. Each time a page is completely written, the block streams that page out as 1024 bytes over a valid/ready interface toward the host-transfer logic. Overruns are detected and counted.

## Interface
- FRAME_LEN, 1024: samples per page; power of two.
- ADR_W, 10: log2(FRAME_LEN).
- DATA_W, 8: sample width (AD9283 output).
- CNT_W, 8: width of drop counter.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- adc_data  in  DATA_W  sample to store this cycle.
- wr_en  in  1  store adc_data at {wr_page, wr_adr} this cycle.
- wr_adr  in  ADR_W  write address from the frame address generator.
- wr_page  in  1  write page from the frame address generator.
- out_data  out  DATA_W  streamed sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the beat when high together with out_valid.
- out_last  out  1  high on beat 1023 of a page.
- out_page  out  1  page currently being streamed.
- overrun  out  1  sticky; a page completed while a stream was in progress.
- ovr_clr  in  1  clears overrun; takes priority over a same-cycle set.
- drop_cnt  out  CNT_W  saturating count of pages discarded unstreamed.

## Operation
- RAM is 2*FRAME_LEN x DATA_W, simple dual-port, 1-cycle registered read. Write address is {wr_page, wr_adr}. RAM contents are not reset.
- Page completion event is a cycle with wr_en=1 and wr_adr=FRAME_LEN-1; the completed page is that cycle's wr_page.
- States:
  - IDLE: out_valid=0. On completion: go to PRIME, rd_page=completed page, rd_idx=0.
  - PRIME: issue RAM read of index 0. Go to STREAM.
  - STREAM: present beats 0..1023 in order. On accept of the out_last beat: go to PRIME with the pending page if pending, else to IDLE.
- Completion while in PRIME or STREAM:
  - Set overrun.
  - If pending is empty, store the page as pending.
  - If pending is full, overwrite pending with the new page and increment drop_cnt (saturating at 2^CNT_W-1).
- Completion in the same cycle as acceptance of the last beat is not an overrun. Go to PRIME with the new page; any existing pending page is dropped and counted.
- Data integrity under overrun is not guaranteed: the writer may overwrite the page being streamed. This is flagged, not prevented.
- Reset mid-stream aborts immediately: state IDLE, pending cleared, no partial completion.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_data=0, out_page=0
  - overrun=0, drop_cnt=0
  - state IDLE, pending empty
- Latency: completion write at cycle T gives out_valid=1 with beat 0 at T+2.
- With out_ready held high: one beat per cycle, 1024 consecutive cycles, out_last at T+1025.
- Backpressure rules:
  - While out_valid=1 and out_ready=0, out_data, out_last and out_page hold stable.
  - out_valid never drops mid-page.
  - No beat is lost or duplicated.
- Between pages: a one-cycle PRIME bubble (out_valid=0) after each last beat.
- overrun sets the cycle after the offending completion. drop_cnt updates the cycle after the drop.

## Structure
- Shared package `sdr_pkg`:
  - FRAME_LEN, ADR_W, DATA_W constants, shared with the frame address generator.
  - State enum {IDLE, PRIME, STREAM}.
- Sub-module `pingpong_ram`: parameterised simple dual-port RAM with registered read, inferable to FPGA block RAM.
- Top level holds the FSM, read index, pending register, output skid/hold register and flags.

## Test plan
- Basic stream: write ramp 0..1023 (mod 256) to page 0 with out_ready=1. Required:
  - beat 0 at T+2
  - bytes 0..255 repeating, 1024 beats
  - out_last on beat 1023, out_page=0
  - no overrun.
- Backpressure: toggle out_ready pseudo-randomly during a page. Required:
  - exactly 1024 accepted beats, in order
  - out_data stable during every stall.
- Continuous alternating pages, consumer at full rate. Required: pages 0,1,0,1 streamed in order, overrun=0, drop_cnt=0.
- Slow consumer (out_ready=1 every 4th cycle) while the writer runs continuously. Required:
  - overrun=1 after the second completion
  - drop_cnt increments on each further completion during the stream
  - ovr_clr pulse returns overrun to 0.
- Last-beat collision: completion in the same cycle as the accepted out_last beat. Required: no overrun; next page beat 0 two cycles later.
- Reset mid-stream at beat 500. Required:
  - out_valid=0 next cycle, overrun=0, drop_cnt=0
  - next completion streams a full 1024-beat page from beat 0.

Source files
------------

// File: rtl/sdr_pkg.sv
// Constants and state type shared by the SDR sample-capture path
// (frame address generator and ping-pong capture buffer).
package sdr_pkg;
  localparam int FRAME_LEN = 1024;
  localparam int ADR_W     = $clog2(FRAME_LEN);
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } buf_state_e;
endpackage

// File: rtl/pingpong_ram.sv
// Simple dual-port RAM with registered, enable-gated read; maps onto FPGA block RAM.
module pingpong_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // rdata_q only moves when re is high, so it doubles as the output hold register.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/frame_pingpong_buf.sv
// Two-page capture buffer: stores ADC samples at the generator's page/address and
// streams every completed page out over valid/ready, flagging and counting overruns.
module frame_pingpong_buf
  import sdr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic              wr_page,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_page,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(FRAME_LEN - 1);

  buf_state_e        state_q, state_d;
  logic [ADR_W-1:0]  idx_q, idx_d;
  logic              rd_page_q, rd_page_d;
  logic              pend_vld_q, pend_vld_d;
  logic              pend_page_q, pend_page_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              comp, acc, is_last, drop_inc, ovr_set;
  logic              ram_re;
  logic [ADR_W:0]    ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign comp    = wr_en && (wr_adr == LAST_IDX);
  assign is_last = (idx_q == LAST_IDX);
  assign acc     = (state_q == STREAM) && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_page_d   = rd_page_q;
    pend_vld_d  = pend_vld_q;
    pend_page_d = pend_page_q;
    drop_inc    = 1'b0;
    ovr_set     = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = {rd_page_q, idx_q};
    case (state_q)
      IDLE: begin
        if (comp) begin
          state_d   = PRIME;
          rd_page_d = wr_page;
          idx_d     = '0;
        end
      end
      PRIME: begin
        ram_re  = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (acc && is_last) begin
          idx_d = '0;
          if (comp) begin
            // A fresh page arriving exactly at end of stream wins; any older pending page is lost.
            state_d    = PRIME;
            rd_page_d  = wr_page;
            drop_inc   = pend_vld_q;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            state_d    = PRIME;
            rd_page_d  = pend_page_q;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (acc) begin
          idx_d     = idx_q + ADR_W'(1);
          ram_re    = 1'b1;
          ram_raddr = {rd_page_q, idx_q + ADR_W'(1)};
        end
      end
      default: state_d = IDLE;
    endcase

    if (comp && (state_q != IDLE) && !(acc && is_last)) begin
      ovr_set     = 1'b1;
      pend_vld_d  = 1'b1;
      pend_page_d = wr_page;
      drop_inc    = pend_vld_q;
    end

    overrun_d = ovr_clr ? 1'b0 : (overrun_q | ovr_set);
    drop_d    = (drop_inc && (drop_q != {CNT_W{1'b1}})) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_page_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_page_q <= 1'b0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_page_q   <= rd_page_d;
      pend_vld_q  <= pend_vld_d;
      pend_page_q <= pend_page_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  pingpong_ram #(
    .ADDR_W(ADR_W + 1),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wr_page, wr_adr}),
    .wdata(adc_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && is_last;
  assign out_page  = rd_page_q;
  assign out_data  = out_valid ? ram_rdata : '0;
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_frame_pingpong_buf.sv
// Bench for frame_pingpong_buf: scenario table plus hand-built corner sequences,
// all checked cycle by cycle against a page-level reference model.
module tb_frame_pingpong_buf;
  import sdr_pkg::*;

  localparam int CW    = 2;
  localparam int LASTB = FRAME_LEN - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] adc_data = '0;
  logic              wr_en = 1'b0;
  logic [ADR_W-1:0]  wr_adr = '0;
  logic              wr_page = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              out_page;
  logic              overrun;
  logic              ovr_clr = 1'b0;
  logic [CW-1:0]     drop_cnt;

  always #5 clk = ~clk;

  frame_pingpong_buf #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_page(wr_page), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_page(out_page), .overrun(overrun), .ovr_clr(ovr_clr),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    int pages; int gap_every; bit rnd_gap; int ready_mode; bit ramp; bit dchk;
    int exp_beats; int exp_ovr; int exp_drop;
  } scn_t;
  scn_t scn[6];

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: page contents, current stream position, one-deep pending slot.
  logic [DATA_W-1:0] ref_mem [2][FRAME_LEN];
  bit m_prime, m_valid, m_page, m_ovr;
  int m_beat, m_drops;
  bit m_pend[$];

  bit data_chk;
  int w_adr; bit w_page;
  int beats, comp_cnt, first_comp, last_comp, first_rise, last_rise, first_last, first_lastacc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_page(input bit p);
    m_prime = 1'b1; m_page = p; m_beat = 0;
  endtask

  task automatic bump_drop();
    if (m_drops < (1 << CW) - 1) m_drops++;
  endtask

  task automatic model_edge();
    bit comp, acc, lastacc, was_prime;
    comp = wr_en && (int'(wr_adr) == LASTB);
    if (wr_en) ref_mem[wr_page][wr_adr] = adc_data;
    if (rst) begin
      m_prime = 0; m_valid = 0; m_page = 0; m_beat = 0; m_ovr = 0; m_drops = 0;
      m_pend.delete();
      return;
    end
    was_prime = m_prime;
    m_prime   = 1'b0;
    acc       = m_valid && out_ready;
    lastacc   = acc && (m_beat == LASTB);
    if (lastacc) begin
      m_valid = 1'b0;
      if (comp) begin
        if (m_pend.size() != 0) bump_drop();
        m_pend.delete();
        start_page(wr_page);
      end else if (m_pend.size() != 0) begin
        start_page(m_pend.pop_front());
      end
    end else begin
      if (acc) m_beat++;
      if (comp) begin
        if (!m_valid && !was_prime) start_page(wr_page);
        else begin
          m_ovr = 1'b1;
          if (m_pend.size() != 0) begin bump_drop(); m_pend.delete(); end
          m_pend.push_back(wr_page);
        end
      end
    end
    if (ovr_clr) m_ovr = 1'b0;
    if (was_prime) m_valid = 1'b1;
  endtask

  task automatic step();
    bit p_stall, p_last, p_page, p_valid;
    logic [DATA_W-1:0] p_data;
    p_valid = out_valid;
    p_stall = out_valid && !out_ready && !rst;
    p_data  = out_data; p_last = out_last; p_page = out_page;
    if (!rst && out_valid && out_ready) begin
      beats++;
      if (out_last && first_lastacc < 0) first_lastacc = cyc;
    end
    if (!rst && wr_en && int'(wr_adr) == LASTB) begin
      comp_cnt++;
      if (first_comp < 0) first_comp = cyc;
      last_comp = cyc;
    end
    model_edge();
    @(posedge clk); #1;
    cyc++;
    chk("valid", int'(out_valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("drop_cnt", int'(drop_cnt), m_drops);
    if (m_valid) begin
      chk("last", int'(out_last), int'(m_beat == LASTB));
      chk("page", int'(out_page), int'(m_page));
      if (data_chk) chk("data", int'(out_data), int'(ref_mem[m_page][m_beat]));
    end else begin
      chk("last_idle", int'(out_last), 0);
    end
    if (p_stall && !rst) begin
      chk("stall_data", int'(out_data), int'(p_data));
      chk("stall_last", int'(out_last), int'(p_last));
      chk("stall_page", int'(out_page), int'(p_page));
    end
    if (out_valid && !p_valid) begin
      if (first_rise < 0) first_rise = cyc;
      last_rise = cyc;
    end
    if (out_valid && out_last && first_last < 0) first_last = cyc;
  endtask

  function automatic bit rdy(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      2:       return (cyc % 4) == 0;
      default: return (cyc % 8) == 0;
    endcase
  endfunction

  task automatic wcycle(input bit we, input bit ready, input bit ramp);
    wr_en     = we;
    wr_adr    = ADR_W'(w_adr);
    wr_page   = w_page;
    adc_data  = ramp ? DATA_W'(w_adr) : DATA_W'($urandom);
    out_ready = ready;
    step();
    ovr_clr = 1'b0;
    if (we) begin
      if (w_adr == LASTB) begin w_adr = 0; w_page = ~w_page; end
      else w_adr++;
    end
  endtask

  task automatic reset_stats();
    beats = 0; comp_cnt = 0; first_comp = -1; last_comp = -1;
    first_rise = -1; last_rise = -1; first_last = -1; first_lastacc = -1;
    w_adr = 0; w_page = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
    step();
    step();
    chk("rst_data", int'(out_data), 0);
    chk("rst_page", int'(out_page), 0);
    rst = 1'b0;
    reset_stats();
  endtask

  task automatic drain(input int lim, input int mode);
    for (int i = 0; i < lim && (m_valid || m_prime || m_pend.size() != 0); i++)
      wcycle(1'b0, rdy(mode), 1'b0);
    chk("drained", int'(out_valid), 0);
  endtask

  task automatic run_scn(input scn_t s, input int id);
    int pw, k;
    bit we;
    do_reset();
    data_chk = s.dchk;
    pw = 0; k = 0;
    for (int i = 0; i < 20000 && pw < s.pages; i++) begin
      we = !((s.gap_every != 0 && (k % s.gap_every) == s.gap_every - 1) ||
             (s.rnd_gap && $urandom_range(0, 31) == 0));
      k++;
      if (we && w_adr == LASTB) pw++;
      wcycle(we, rdy(s.ready_mode), s.ramp);
    end
    drain(20000, s.ready_mode);
    chk($sformatf("s%0d_beats", id), beats, s.exp_beats);
    chk($sformatf("s%0d_overrun", id), int'(overrun), s.exp_ovr);
    chk($sformatf("s%0d_drops", id), int'(drop_cnt), s.exp_drop);
    chk($sformatf("s%0d_first_lat", id), first_rise - first_comp, 2);
    if (s.ready_mode == 0) chk($sformatf("s%0d_last_lat", id), first_last - first_comp, 1025);
    ovr_clr = 1'b1;
    wcycle(1'b0, 1'b1, 1'b0);
    chk($sformatf("s%0d_ovr_clr", id), int'(overrun), 0);
  endtask

  initial begin
    scn[0] = '{pages: 1, gap_every: 0,  rnd_gap: 0, ready_mode: 0, ramp: 1, dchk: 1,
               exp_beats: 1024, exp_ovr: 0, exp_drop: 0};
    scn[1] = '{pages: 1, gap_every: 0,  rnd_gap: 0, ready_mode: 1, ramp: 0, dchk: 1,
               exp_beats: 1024, exp_ovr: 0, exp_drop: 0};
    scn[2] = '{pages: 4, gap_every: 16, rnd_gap: 0, ready_mode: 0, ramp: 0, dchk: 1,
               exp_beats: 4096, exp_ovr: 0, exp_drop: 0};
    scn[3] = '{pages: 4, gap_every: 0,  rnd_gap: 0, ready_mode: 2, ramp: 0, dchk: 0,
               exp_beats: 2048, exp_ovr: 1, exp_drop: 2};
    scn[4] = '{pages: 3, gap_every: 2,  rnd_gap: 1, ready_mode: 1, ramp: 0, dchk: 1,
               exp_beats: 3072, exp_ovr: 0, exp_drop: 0};
    scn[5] = '{pages: 7, gap_every: 0,  rnd_gap: 0, ready_mode: 3, ramp: 0, dchk: 0,
               exp_beats: 2048, exp_ovr: 1, exp_drop: 3};
    reset_stats();

    for (int r = 0; r < 6; r++) run_scn(scn[r], r);

    // Next page completes in the very cycle the last beat is accepted.
    do_reset();
    data_chk = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) wcycle(1'b1, 1'b1, 1'b0);
    wcycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) wcycle(1'b1, 1'b1, 1'b0);
    drain(4000, 0);
    chk("coll_align", first_lastacc, last_comp);
    chk("coll_beats", beats, 2048);
    chk("coll_overrun", int'(overrun), 0);
    chk("coll_drops", int'(drop_cnt), 0);
    chk("coll_next_lat", last_rise - last_comp, 2);

    // ovr_clr against a same-cycle set, then reset in the middle of a stream.
    do_reset();
    data_chk = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      bit clr_now;
      if (m_valid && m_beat == 500) break;
      clr_now = (w_adr == LASTB) && (comp_cnt == 1);
      if (clr_now) ovr_clr = 1'b1;
      wcycle(1'b1, rdy(3), 1'b0);
      if (clr_now) chk("clr_priority", int'(overrun), 0);
    end
    chk("at_beat500", int'(out_valid), 1);
    chk("pre_rst_overrun", int'(overrun), 1);
    chk("pre_rst_drops", int'(drop_cnt), 2);
    rst = 1'b1;
    wcycle(1'b0, 1'b1, 1'b0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_drops", int'(drop_cnt), 0);
    rst = 1'b0;
    reset_stats();
    data_chk = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) wcycle(1'b1, 1'b1, 1'b1);
    drain(3000, 0);
    chk("post_rst_beats", beats, 1024);
    chk("post_rst_lat", first_rise - first_comp, 2);
    chk("post_rst_last", first_last - first_comp, 1025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
